// File: rtl/reg_file_mp.sv
// Multi-port integer register file with a power-up init sequencer and optional write-to-read bypass.
// x0 always reads as zero. Reads are combinational; writes land on the rising clock edge.
module reg_file_mp #(
    parameter int XLEN      = 32,
    parameter int NREGS     = 32,
    parameter int NRD       = 2,
    parameter int NWR       = 1,
    parameter int BYPASS    = 0,
    parameter int INIT_BASE = 128,
    localparam int AW       = $clog2(NREGS)
) (
    input  logic                 clk,
    input  logic                 rst,
    output logic                 ready,
    input  logic [NRD*AW-1:0]    rd_addr,
    output logic [NRD*XLEN-1:0]  rd_data,
    input  logic [NWR-1:0]       wr_en,
    input  logic [NWR*AW-1:0]    wr_addr,
    input  logic [NWR*XLEN-1:0]  wr_data
);

    typedef enum logic [0:0] {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } state_e;

    // One bit wider than an address so the index can reach NREGS without wrapping.
    localparam logic [AW:0] LAST_IDX = (AW+1)'(NREGS - 1);

    state_e          state_q, state_d;
    logic [AW:0]     init_idx_q, init_idx_d;
    logic            ready_q;
    logic [XLEN-1:0] mem_q [NREGS];
    logic [XLEN-1:0] init_val_s;
    logic [AW-1:0]   rd_addr_s [NRD];
    logic [XLEN-1:0] rd_val_s  [NRD];

    assign init_val_s = XLEN'(INIT_BASE) + XLEN'(init_idx_q) - XLEN'(1);
    assign ready      = ready_q;

    // Next-state logic for the init sequencer.
    always_comb begin
        state_d    = state_q;
        init_idx_d = init_idx_q;
        case (state_q)
            ST_INIT: begin
                init_idx_d = init_idx_q + (AW+1)'(1);
                if (init_idx_q == LAST_IDX) begin
                    state_d = ST_RUN;
                end else begin
                    state_d = ST_INIT;
                end
            end
            ST_RUN: begin
                state_d = ST_RUN;
            end
            default: begin
                state_d    = ST_INIT;
                init_idx_d = (AW+1)'(1);
            end
        endcase
    end

    // State, init index and ready registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= ST_INIT;
            init_idx_q <= (AW+1)'(1);
            ready_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            init_idx_q <= init_idx_d;
            ready_q    <= (state_d == ST_RUN);
        end
    end

    // Storage array: init pattern during INIT, user writes afterwards; higher port wins on a clash.
    always_ff @(posedge clk) begin
        if (state_q == ST_INIT) begin
            mem_q[init_idx_q[AW-1:0]] <= init_val_s;
        end else begin
            for (int k = 0; k < NWR; k++) begin
                if (wr_en[k] && (wr_addr[k*AW +: AW] != AW'(0))) begin
                    mem_q[wr_addr[k*AW +: AW]] <= wr_data[k*XLEN +: XLEN];
                end
            end
        end
    end

    // Read ports with optional same-cycle bypass; x0 and the INIT state force zero.
    always_comb begin
        rd_data = {(NRD*XLEN){1'b0}};
        for (int r = 0; r < NRD; r++) begin
            rd_addr_s[r] = rd_addr[r*AW +: AW];
            rd_val_s[r]  = mem_q[rd_addr_s[r]];
            if (BYPASS != 32'sd0) begin
                for (int k = 0; k < NWR; k++) begin
                    if (wr_en[k] && (wr_addr[k*AW +: AW] == rd_addr_s[r])) begin
                        rd_val_s[r] = wr_data[k*XLEN +: XLEN];
                    end else begin
                        rd_val_s[r] = rd_val_s[r];
                    end
                end
            end else begin
                rd_val_s[r] = rd_val_s[r];
            end
            if ((state_q != ST_RUN) || (rd_addr_s[r] == AW'(0))) begin
                rd_data[r*XLEN +: XLEN] = XLEN'(0);
            end else begin
                rd_data[r*XLEN +: XLEN] = rd_val_s[r];
            end
        end
    end

endmodule

// File: tb/tb_reg_file_mp.sv
// Scoreboard bench for reg_file_mp: two instances (BYPASS=0 and BYPASS=1, both NWR=2) share stimulus.
module tb_reg_file_mp;

    localparam int XLEN  = 32;
    localparam int NREGS = 32;
    localparam int NRD   = 2;
    localparam int NWR   = 2;
    localparam int AW    = 5;

    logic                 clk = 1'b0;
    logic                 rst = 1'b0;
    logic                 ready0, ready1;
    logic [NRD*AW-1:0]    rd_addr;
    logic [NRD*XLEN-1:0]  rd_data0, rd_data1;
    logic [NWR-1:0]       wr_en;
    logic [NWR*AW-1:0]    wr_addr;
    logic [NWR*XLEN-1:0]  wr_data;

    typedef struct {
        string       tag;
        int          sel;
        logic [31:0] exp;
    } sb_t;

    sb_t         sb[$];
    int          n_checks = 0;
    int          n_errors = 0;
    logic [31:0] model [NREGS];

    always #5 clk = ~clk;

    reg_file_mp #(.XLEN(XLEN), .NREGS(NREGS), .NRD(NRD), .NWR(NWR), .BYPASS(0), .INIT_BASE(128)) dut_nb (
        .clk(clk), .rst(rst), .ready(ready0), .rd_addr(rd_addr), .rd_data(rd_data0),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data)
    );

    reg_file_mp #(.XLEN(XLEN), .NREGS(NREGS), .NRD(NRD), .NWR(NWR), .BYPASS(1), .INIT_BASE(128)) dut_bp (
        .clk(clk), .rst(rst), .ready(ready1), .rd_addr(rd_addr), .rd_data(rd_data1),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data)
    );

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] observe(input int sel);
        case (sel)
            0:       return rd_data0[31:0];
            1:       return rd_data0[63:32];
            2:       return rd_data1[31:0];
            3:       return rd_data1[63:32];
            4:       return {31'd0, ready0};
            5:       return {31'd0, ready1};
            default: return 32'hxxxx_xxxx;
        endcase
    endfunction

    task automatic push(input string tag, input int sel, input logic [31:0] exp);
        sb.push_back('{tag, sel, exp});
    endtask

    task automatic push_rd(input string tag, input int port, input logic [31:0] exp_nb, input logic [31:0] exp_bp);
        push({tag, "_nb"}, port, exp_nb);
        push({tag, "_bp"}, 2 + port, exp_bp);
    endtask

    task automatic push_ready(input string tag, input logic exp);
        push({tag, "_nb"}, 4, {31'd0, exp});
        push({tag, "_bp"}, 5, {31'd0, exp});
    endtask

    task automatic set_rd(input logic [AW-1:0] a0, input logic [AW-1:0] a1);
        rd_addr = {a1, a0};
    endtask

    task automatic set_wr(input logic [1:0] en, input logic [AW-1:0] a0, input logic [31:0] d0,
                          input logic [AW-1:0] a1, input logic [31:0] d1);
        wr_en   = en;
        wr_addr = {a1, a0};
        wr_data = {d1, d0};
    endtask

    // Expected read for one port, from the bench's own copy of the register contents.
    function automatic logic [31:0] exp_read(input logic [AW-1:0] a, input bit bypass);
        logic [31:0] v;
        if (a == 5'd0) return 32'd0;
        v = model[a];
        if (bypass) begin
            for (int k = 0; k < NWR; k++) begin
                if (wr_en[k] && (wr_addr[k*AW +: AW] == a)) v = wr_data[k*XLEN +: XLEN];
            end
        end
        return v;
    endfunction

    task automatic commit_model();
        for (int k = 0; k < NWR; k++) begin
            if (wr_en[k] && (wr_addr[k*AW +: AW] != 5'd0)) model[wr_addr[k*AW +: AW]] = wr_data[k*XLEN +: XLEN];
        end
    endtask

    // Sample on the falling edge, drain the scoreboard, then advance to just after the next rising edge.
    task automatic step();
        sb_t e;
        @(negedge clk);
        while (sb.size() > 0) begin
            e = sb.pop_front();
            check_eq(e.tag, observe(e.sel), e.exp);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic cycle();
        commit_model();
        step();
    endtask

    task automatic run_init(input bit hold_writes);
        logic [AW-1:0] ra;
        for (int i = 0; i < NREGS - 1; i++) begin
            if (hold_writes) begin
                set_wr(2'b01, 5'd9, 32'h0000_FFFF, 5'd0, 32'd0);
                ra = 5'd9;
            end else begin
                set_wr(2'b00, 5'd0, 32'd0, 5'd0, 32'd0);
                ra = 5'($urandom_range(1, 31));
            end
            set_rd(ra, 5'($urandom_range(0, 31)));
            push_ready("init_ready", 1'b0);
            push_rd("init_rd0", 0, 32'd0, 32'd0);
            push_rd("init_rd1", 1, 32'd0, 32'd0);
            step();
        end
        set_wr(2'b00, 5'd0, 32'd0, 5'd0, 32'd0);
        push_ready("ready_up", 1'b1);
        step();
        model[0] = 32'd0;
        for (int i = 1; i < NREGS; i++) model[i] = 32'd128 + 32'(i) - 32'd1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [AW-1:0] a0, a1;
        set_wr(2'b00, 5'd0, 32'd0, 5'd0, 32'd0);
        set_rd(5'd1, 5'd5);
        @(posedge clk);
        #1;
        push_ready("rst_ready", 1'b0);
        push_rd("rst_rd0", 0, 32'd0, 32'd0);
        step();
        rst = 1'b1;
        run_init(1'b0);

        // Power-up contents
        set_rd(5'd5, 5'd1);
        push_rd("x5", 0, 32'd132, 32'd132);
        push_rd("x1", 1, 32'd128, 32'd128);
        cycle();
        set_rd(5'd31, 5'd0);
        push_rd("x31", 0, 32'd158, 32'd158);
        push_rd("x0", 1, 32'd0, 32'd0);
        cycle();

        // x0 stays zero even with a same-cycle write and bypass
        set_wr(2'b01, 5'd0, 32'hDEAD_BEEF, 5'd0, 32'd0);
        set_rd(5'd0, 5'd0);
        push_rd("x0_wr_p0", 0, 32'd0, 32'd0);
        push_rd("x0_wr_p1", 1, 32'd0, 32'd0);
        cycle();
        set_wr(2'b00, 5'd0, 32'd0, 5'd0, 32'd0);
        push_rd("x0_after_p0", 0, 32'd0, 32'd0);
        push_rd("x0_after_p1", 1, 32'd0, 32'd0);
        cycle();

        // Both write ports to x7: port 1 wins
        set_wr(2'b11, 5'd7, 32'h11, 5'd7, 32'h22);
        set_rd(5'd7, 5'd7);
        push_rd("x7_same_p0", 0, 32'd134, 32'h22);
        push_rd("x7_same_p1", 1, 32'd134, 32'h22);
        cycle();
        set_wr(2'b00, 5'd0, 32'd0, 5'd0, 32'd0);
        push_rd("x7_next_p0", 0, 32'h22, 32'h22);
        push_rd("x7_next_p1", 1, 32'h22, 32'h22);
        cycle();

        // Bypass versus registered visibility
        set_wr(2'b01, 5'd3, 32'hCAFE, 5'd0, 32'd0);
        set_rd(5'd3, 5'd3);
        push_rd("x3_same_p0", 0, 32'd130, 32'hCAFE);
        push_rd("x3_same_p1", 1, 32'd130, 32'hCAFE);
        cycle();
        set_wr(2'b00, 5'd0, 32'd0, 5'd0, 32'd0);
        push_rd("x3_next", 0, 32'hCAFE, 32'hCAFE);
        cycle();

        // Distinct addresses on both write ports, each bypassed to one read port
        set_wr(2'b11, 5'd13, 32'h5678, 5'd12, 32'h1234);
        set_rd(5'd12, 5'd13);
        push_rd("x12_byp", 0, 32'd139, 32'h1234);
        push_rd("x13_byp", 1, 32'd140, 32'h5678);
        cycle();

        // Random traffic with collisions concentrated on low addresses
        for (int i = 0; i < 60; i++) begin
            set_wr(2'($urandom_range(0, 3)), 5'($urandom_range(0, 7)), $urandom,
                   5'($urandom_range(0, 7)), $urandom);
            a0 = 5'($urandom_range(0, 7));
            a1 = 5'($urandom_range(0, 31));
            set_rd(a0, a1);
            push_rd("rand_p0", 0, exp_read(a0, 1'b0), exp_read(a0, 1'b1));
            push_rd("rand_p1", 1, exp_read(a1, 1'b0), exp_read(a1, 1'b1));
            cycle();
        end
        set_wr(2'b00, 5'd0, 32'd0, 5'd0, 32'd0);

        // Reset from RUN, then reset again mid-init, then init with writes held active
        rst = 1'b0;
        set_rd(5'd1, 5'd5);
        push_ready("run_rst_ready", 1'b0);
        push_rd("run_rst_rd0", 0, 32'd0, 32'd0);
        push_rd("run_rst_rd1", 1, 32'd0, 32'd0);
        step();
        rst = 1'b1;
        for (int i = 0; i < 10; i++) begin
            push_ready("part_init_ready", 1'b0);
            step();
        end
        rst = 1'b0;
        for (int i = 0; i < 2; i++) begin
            push_ready("mid_rst_ready", 1'b0);
            step();
        end
        rst = 1'b1;
        run_init(1'b1);

        set_rd(5'd9, 5'd1);
        push_rd("x9_after_init", 0, 32'd136, 32'd136);
        push_rd("x1_again", 1, 32'd128, 32'd128);
        cycle();
        set_rd(5'd31, 5'd5);
        push_rd("x31_again", 0, 32'd158, 32'd158);
        push_rd("x5_again", 1, 32'd132, 32'd132);
        cycle();
        set_rd(5'd7, 5'd3);
        push_rd("x7_reinit", 0, 32'd134, 32'd134);
        push_rd("x3_reinit", 1, 32'd130, 32'd130);
        cycle();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
